// File: rtl/regfile_writeback.sv
// regfile_writeback: writeback side of the architectural register file.
// Execution-unit results enter a small FIFO and drain one per cycle into the
// 32 x XLEN register array. x0 is hardwired to zero, so x0 writes are
// acknowledged but never queued. Two combinational read ports serve decode.
// Optional build macro REGFILE_BYPASS_EN: read ports also forward the
// youngest queued (uncommitted) write to the selected register.
module regfile_writeback #(
    parameter int XLEN           = 32,
    parameter int REG_SELECT_LEN = 5,
    parameter int DEPTH          = 4
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      wb_valid,
    output logic                      wb_ready,
    input  logic [REG_SELECT_LEN-1:0] wb_rd,
    input  logic [XLEN-1:0]           wb_data,
    input  logic [REG_SELECT_LEN-1:0] rs1_sel,
    output logic [XLEN-1:0]           rs1_data,
    input  logic [REG_SELECT_LEN-1:0] rs2_sel,
    output logic [XLEN-1:0]           rs2_data,
    output logic [$clog2(DEPTH):0]    pending,
    output logic                      empty
);

    localparam int PTR_W    = $clog2(DEPTH);
    localparam int CNT_W    = PTR_W + 1;
    localparam int NUM_REGS = 2 ** REG_SELECT_LEN;
    localparam logic [CNT_W-1:0] FULL_COUNT = CNT_W'(DEPTH);

    typedef struct packed {
        logic [REG_SELECT_LEN-1:0] rd;
        logic [XLEN-1:0]           data;
    } entry_t;

    entry_t            queue_mem [DEPTH];
    logic [XLEN-1:0]   regs [NUM_REGS];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [CNT_W-1:0]  count;
    logic              live;
    logic              accept;
    logic              push;
    logic              pop;
    entry_t            head;

    // Ready is held low in reset and for the cycle after release; afterwards it
    // depends only on the registered occupancy, never on wb_valid.
    assign wb_ready = live && (count != FULL_COUNT);
    assign accept   = wb_valid && wb_ready;
    assign push     = accept && (wb_rd != '0);
    assign pop      = (count != '0);
    assign head     = queue_mem[rd_ptr];
    assign pending  = count;
    assign empty    = (count == '0);

    // Becomes 1 on the first clock edge after reset release.
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            live <= 1'b0;
        end else begin
            live <= 1'b1;
        end
    end

    // Queue pointers and occupancy; accept and drain in one cycle leave count unchanged.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Queue payload storage.
    // NOTE: payload entries carry no reset; count gates every use, so stale contents are never observed.
    always_ff @(posedge clk) begin
        if (push) begin
            queue_mem[wr_ptr] <= '{rd: wb_rd, data: wb_data};
        end
    end

    // Architectural array: clears on reset, commits the queue head every non-empty cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs[i] <= '0;
            end
        end else if (pop) begin
            regs[head.rd] <= head.data;
        end
    end

    // Two identical combinational read ports.
    for (genvar p = 0; p < 2; p++) begin : g_read
        logic [REG_SELECT_LEN-1:0] sel;
        logic [XLEN-1:0]           val;

        assign sel = (p == 0) ? rs1_sel : rs2_sel;

        // Array lookup, optionally overridden by the youngest matching queued write.
        // NOTE: val gets a default before any conditional update, so no latch is inferred.
        always_comb begin
            val = '0;
            if (sel != '0) begin
                val = regs[sel];
            end
`ifdef REGFILE_BYPASS_EN
            // Scan oldest to youngest so the last match wins.
            for (int i = 0; i < DEPTH; i++) begin
                if ((CNT_W'(i) < count) && (sel != '0) &&
                    (queue_mem[rd_ptr + PTR_W'(i)].rd == sel)) begin
                    val = queue_mem[rd_ptr + PTR_W'(i)].data;
                end
            end
`else
            // Committed contents only; the queue is invisible to readers.
`endif
        end
    end

    assign rs1_data = g_read[0].val;
    assign rs2_data = g_read[1].val;

endmodule

// File: tb/tb_regfile_writeback.sv
// tb_regfile_writeback: randomized and directed stimulus with a scoreboard.
// The driver computes each cycle's expected outputs from a queue-based
// reference model and pushes them; a monitor pops and compares at negedge.
module tb_regfile_writeback;

    localparam int XLEN  = 32;
    localparam int RSL   = 5;
    localparam int DEPTH = 4;
    localparam int CW    = $clog2(DEPTH) + 1;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            wb_valid;
    logic            wb_ready;
    logic [RSL-1:0]  wb_rd;
    logic [XLEN-1:0] wb_data;
    logic [RSL-1:0]  rs1_sel;
    logic [XLEN-1:0] rs1_data;
    logic [RSL-1:0]  rs2_sel;
    logic [XLEN-1:0] rs2_data;
    logic [CW-1:0]   pending;
    logic            empty;

    always #5 clk = ~clk;

    regfile_writeback #(.XLEN(XLEN), .REG_SELECT_LEN(RSL), .DEPTH(DEPTH)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .wb_valid (wb_valid),
        .wb_ready (wb_ready),
        .wb_rd    (wb_rd),
        .wb_data  (wb_data),
        .rs1_sel  (rs1_sel),
        .rs1_data (rs1_data),
        .rs2_sel  (rs2_sel),
        .rs2_data (rs2_data),
        .pending  (pending),
        .empty    (empty)
    );

    typedef struct {
        logic [RSL-1:0]  rd;
        logic [XLEN-1:0] data;
    } wr_t;

    typedef struct {
        logic            ready;
        int              pend;
        logic [XLEN-1:0] r1;
        logic [XLEN-1:0] r2;
    } exp_t;

    // Reference model: committed registers plus an ordered list of queued writes.
    logic [XLEN-1:0] m_regs [32];
    wr_t             m_q [$];
    bit              m_live;
    exp_t            exp_q [$];

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [XLEN-1:0] m_read(input logic [RSL-1:0] sel);
        logic [XLEN-1:0] v;
        if (sel == 0) return '0;
        v = m_regs[sel];
`ifdef REGFILE_BYPASS_EN
        foreach (m_q[i]) begin
            if (m_q[i].rd == sel) v = m_q[i].data;
        end
`endif
        return v;
    endfunction

    function automatic bit m_ready();
        return m_live && (m_q.size() != DEPTH);
    endfunction

    // One clock: drive, record expectation, step the model across the edge.
    task automatic cycle(input logic v, input logic [RSL-1:0] rd, input logic [XLEN-1:0] d,
                         input logic [RSL-1:0] s1, input logic [RSL-1:0] s2, output bit acc);
        exp_t e;
        wr_t  h;
        bit   rdy;
        wb_valid = v;
        wb_rd    = rd;
        wb_data  = d;
        rs1_sel  = s1;
        rs2_sel  = s2;
        rdy      = m_ready();
        e.ready  = rdy;
        e.pend   = m_q.size();
        e.r1     = m_read(s1);
        e.r2     = m_read(s2);
        exp_q.push_back(e);
        @(posedge clk);
        acc = v && rdy;
        if (m_q.size() != 0) begin
            h = m_q.pop_front();
            m_regs[h.rd] = h.data;
        end
        if (acc && rd != 0) begin
            h.rd   = rd;
            h.data = d;
            m_q.push_back(h);
        end
        m_live = 1'b1;
        #1;
    endtask

    // Hold a request until accepted, with a bounded wait.
    task automatic send(input logic [RSL-1:0] rd, input logic [XLEN-1:0] d,
                        input logic [RSL-1:0] s1, input logic [RSL-1:0] s2);
        bit acc = 1'b0;
        int n = 0;
        while (!acc && n < 20) begin
            cycle(1'b1, rd, d, s1, s2, acc);
            n++;
        end
        if (!acc) begin
            checks++;
            errors++;
            $display("FAIL send_timeout actual=not_accepted expected=accepted rd=%0d", rd);
        end
    endtask

    task automatic idle(input int n, input logic [RSL-1:0] s1, input logic [RSL-1:0] s2);
        bit acc;
        for (int i = 0; i < n; i++) begin
            cycle(1'b0, '0, '0, s1, s2, acc);
        end
    endtask

    // Monitor: compare the oldest expectation with the DUT away from the clock edge.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("wb_ready", {31'd0, wb_ready}, {31'd0, e.ready});
                check("pending",  32'(pending), 32'(e.pend));
                check("empty",    {31'd0, empty}, {31'd0, e.pend == 0});
                check("rs1_data", rs1_data, e.r1);
                check("rs2_data", rs2_data, e.r2);
            end
        end
    end

    initial begin
        bit acc;
        wb_valid = 1'b0;
        wb_rd    = '0;
        wb_data  = '0;
        rs1_sel  = '0;
        rs2_sel  = '0;
        m_live   = 1'b0;
        for (int i = 0; i < 32; i++) m_regs[i] = '0;

        // Reset release: ready stays low until the first edge.
        repeat (2) @(negedge clk);
        #1 rst_n = 1'b1;
        #1 check("ready_before_first_edge", {31'd0, wb_ready}, 32'd0);
        @(posedge clk);
        m_live = 1'b1;
        #1;

        // Basic latency: x5 visible only after the commit edge.
        cycle(1'b1, 5'd5, 32'h0000_1234, 5'd5, 5'd0, acc);
        idle(3, 5'd5, 5'd0);

        // x0 write is acknowledged but never queued.
        send(5'd0, 32'hFFFF_FFFF, 5'd0, 5'd0);
        idle(2, 5'd0, 5'd0);

        // Back-to-back writes x1..x6 = 1..6, then read them all back.
        for (int i = 1; i <= 6; i++) send(RSL'(i), XLEN'(i), RSL'(i), 5'd5);
        idle(3, 5'd1, 5'd2);
        for (int i = 1; i <= 6; i += 2) idle(1, RSL'(i), RSL'(i + 1));

        // Same-register ordering: the youngest value wins.
        send(5'd7, 32'hA, 5'd7, 5'd7);
        send(5'd7, 32'hB, 5'd7, 5'd7);
        send(5'd7, 32'hC, 5'd7, 5'd0);
        idle(3, 5'd7, 5'd0);

        // Pending-entry reads of x9 (forwarded only with bypass).
        send(5'd9, 32'h11, 5'd9, 5'd0);
        send(5'd9, 32'h22, 5'd9, 5'd9);
        idle(3, 5'd9, 5'd9);

        // Reset mid-operation with a write still queued.
        send(5'd10, 32'h1010, 5'd10, 5'd11);
        send(5'd11, 32'h1111, 5'd10, 5'd11);
        send(5'd12, 32'h1212, 5'd12, 5'd11);
        wb_valid = 1'b0;
        @(negedge clk);
        #1 rst_n = 1'b0;
        #1;
        check("reset_pending", 32'(pending), 32'd0);
        check("reset_empty",   {31'd0, empty}, 32'd1);
        check("reset_ready",   {31'd0, wb_ready}, 32'd0);
        m_q.delete();
        for (int i = 0; i < 32; i++) m_regs[i] = '0;
        m_live = 1'b0;
        #1 rst_n = 1'b1;
        #1 check("ready_after_release", {31'd0, wb_ready}, 32'd0);
        @(posedge clk);
        m_live = 1'b1;
        #1;
        idle(1, 5'd10, 5'd11);
        idle(1, 5'd12, 5'd5);

        // Randomized traffic on a small register window to force collisions.
        for (int n = 0; n < 400; n++) begin
            cycle(1'($urandom_range(0, 1)), RSL'($urandom_range(0, 7)), $urandom,
                  RSL'($urandom_range(0, 7)), RSL'($urandom_range(0, 7)), acc);
        end
        idle(4, 5'd1, 5'd2);

        @(negedge clk);
        #1 check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
